vref_sweep_ctrl: RTL
====================

Name: vref_sweep_ctrl

Overview:
- Sequences the receiver reference-voltage calibration sweep inside MBTRAIN (VALVREF/DATAVREF steps).
- Runs only while the RX-side calibration FSM holds the point-test phase.
- For each code from MIN_CODE to MAX_CODE: drives the analog Vref control word, waits for settling, enables the point-test block and collects the lane results.
- Finds the longest contiguous all-lanes-pass window and parks the Vref code at the window centre.

Parameters:
CODE_W, 4, width of Vref control word
LANES, 16, number of lanes reported by point test
MIN_CODE, 0, first code swept
MAX_CODE, 15, last code swept (MAX_CODE >= MIN_CODE)
SETTLE_CYCLES, 8, clk cycles held after each code change before point test (>=1)
DEFAULT_CODE, 8, code driven in idle and when no code passes

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_en  in  1  sweep enable; level; deassertion aborts
i_pt_done  in  1  one-cycle pulse: point test for current code finished
i_lanes_result  in  LANES  per-lane pass (1) / fail (0); valid with i_pt_done
i_lane_mask  in  LANES  1 = lane participates in pass decision
o_vref_code  out  CODE_W  analog Vref control word
o_pt_en  out  1  point-test enable
o_done  out  1  sweep complete, held until i_en low
o_pass  out  1  at least one passing code found; valid while o_done
o_best_code  out  CODE_W  selected centre code; valid while o_done

Behaviour:
- Reset values: o_vref_code=DEFAULT_CODE, o_best_code=DEFAULT_CODE, all other outputs 0. Internal window registers are cleared.
- All outputs are registered.
- States and transitions:
  - IDLE: wait for i_en. On i_en, load code=MIN_CODE, clear window registers, go to SETTLE.
  - SETTLE: o_vref_code=code. Count SETTLE_CYCLES cycles, then go to RUN_PT.
  - RUN_PT: o_pt_en=1 from the first RUN_PT cycle. When i_pt_done is sampled, latch the pass decision, go to EVAL, and drop o_pt_en on the next edge.
  - EVAL: one cycle. If code==MAX_CODE, go to DONE; else code<=code+1 and go to SETTLE.
  - DONE: o_done=1, o_pass and o_best_code valid, o_vref_code=o_best_code. Stay until i_en=0, then go to IDLE.
- Pass decision: code passes iff (i_lanes_result | ~i_lane_mask) is all ones AND i_lane_mask != 0. An all-zero mask means fail.
- Window tracking uses counters of CODE_W+1 bits (cur_start, cur_len, best_start, best_len), updated in EVAL:
  - Pass: if cur_len==0, cur_start=code; then cur_len+1. If the new cur_len > best_len (strict, so ties keep the earlier window), copy it to best.
  - Fail: cur_len=0.
- Centre: best_code = best_start + ((best_len-1)>>1), i.e. floor to the lower-middle code.
- If best_len==0: o_pass=0, o_best_code=DEFAULT_CODE.
- Total latency with no stalls: (MAX_CODE-MIN_CODE+1)*(SETTLE_CYCLES+pt_latency+2) cycles.
- i_pt_done outside RUN_PT is ignored. i_pt_done in the same cycle as RUN_PT entry is ignored; o_pt_en must already be high.
- Abort: i_en=0 in any state goes to IDLE on the next edge. o_pt_en=0, o_done=0, o_pass=0, o_vref_code=DEFAULT_CODE; a partial window is discarded.
- Re-assertion of i_en after DONE/IDLE starts a fresh sweep.
- Code counter never wraps: MAX_CODE=2^CODE_W-1 is handled by the EVAL terminal check before incrementing.

Optional Feature:
- Macro VREF_SWEEP_BITMAP_EN adds output o_pass_map [2^CODE_W-1:0].
- With the macro: bit[code] is set in EVAL when that code passes; the map is cleared on sweep start and on abort, reset 0, and valid while o_done.
- Without the macro: port and register are absent; all other behaviour is identical.

Test Plan:
- Defaults (MIN 0, MAX 15, SETTLE 8), mask 16'hFFFF, all lanes pass only for codes 4..9 -> o_done=1, o_pass=1, o_best_code=6, o_vref_code=6.
- Windows 2..3 and 10..11 (equal length 2) -> o_best_code=2 (earlier window wins ties).
- No code passes -> o_pass=0, o_best_code=8, o_vref_code=8 in DONE.
- Mask 16'h00FF, lanes 8..15 always fail, lanes 0..7 pass for codes 0..15 -> o_best_code=7; mask 16'h0000 -> o_pass=0.
- Deassert i_en during RUN_PT of code 5 -> next cycle o_pt_en=0, o_vref_code=8, o_done=0; re-enable -> sweep restarts at code 0 with exactly SETTLE_CYCLES settling before o_pt_en.
- Stray i_pt_done pulse during SETTLE -> ignored; code count and pass results unchanged. With VREF_SWEEP_BITMAP_EN and pass 4..9, o_pass_map=16'h03F0.

Source files
------------

// File: rtl/vref_sweep_ctrl.sv
// Receiver Vref calibration sweep: steps the Vref code, runs a point test per code and parks the
// code at the centre of the longest all-lanes-pass window. Optional VREF_SWEEP_BITMAP_EN adds o_pass_map.
module vref_sweep_ctrl #(
  parameter int unsigned CODE_W        = 4,
  parameter int unsigned LANES         = 16,
  parameter int unsigned MIN_CODE      = 0,
  parameter int unsigned MAX_CODE      = 15,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned DEFAULT_CODE  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic                 i_pt_done,
  input  logic [LANES-1:0]     i_lanes_result,
  input  logic [LANES-1:0]     i_lane_mask,
  output logic [CODE_W-1:0]    o_vref_code,
  output logic                 o_pt_en,
  output logic                 o_done,
  output logic                 o_pass,
`ifdef VREF_SWEEP_BITMAP_EN
  output logic [CODE_W-1:0]    o_best_code,
  output logic [2**CODE_W-1:0] o_pass_map
`else
  output logic [CODE_W-1:0]    o_best_code
`endif
);

  localparam int unsigned CntW   = CODE_W + 1;
  localparam int unsigned SetW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned MapW   = 2 ** CODE_W;

  localparam logic [CODE_W-1:0] MinCode     = CODE_W'(MIN_CODE);
  localparam logic [CODE_W-1:0] MaxCode     = CODE_W'(MAX_CODE);
  localparam logic [CODE_W-1:0] DefaultCode = CODE_W'(DEFAULT_CODE);
  localparam logic [SetW-1:0]   SettleLast  = SetW'(SETTLE_CYCLES - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSettle = 3'd1;
  localparam logic [2:0] StRunPt  = 3'd2;
  localparam logic [2:0] StEval   = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [SetW-1:0]   settle_cnt_q, settle_cnt_d;
  logic              pt_pass_q, pt_pass_d;
  logic [CntW-1:0]   cur_start_q, cur_start_d;
  logic [CntW-1:0]   cur_len_q, cur_len_d;
  logic [CntW-1:0]   best_start_q, best_start_d;
  logic [CntW-1:0]   best_len_q, best_len_d;
  logic [CODE_W-1:0] vref_code_q, vref_code_d;
  logic              pt_en_q, pt_en_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CODE_W-1:0] best_code_q, best_code_d;
  logic [MapW-1:0]   pass_map_q, pass_map_d;

  logic              lane_ok;
  logic [CntW-1:0]   win_cur_start, win_cur_len, win_best_start, win_best_len;
  logic [CntW-1:0]   win_centre;
  logic [CODE_W-1:0] code_inc;

  // Masked-out lanes count as passing; an empty mask can never pass.
  assign lane_ok  = (&(i_lanes_result | ~i_lane_mask)) && (|i_lane_mask);
  assign code_inc = code_q + CODE_W'(1);

  // Window update for the code being evaluated, shared by EVAL commit and DONE centre.
  always_comb begin
    win_cur_start  = cur_start_q;
    win_cur_len    = cur_len_q;
    win_best_start = best_start_q;
    win_best_len   = best_len_q;
    if (pt_pass_q) begin
      if (cur_len_q == '0) begin
        win_cur_start = {1'b0, code_q};
      end
      win_cur_len = cur_len_q + CntW'(1);
      // Strict compare keeps the earlier window on ties.
      if (win_cur_len > best_len_q) begin
        win_best_start = win_cur_start;
        win_best_len   = win_cur_len;
      end
    end else begin
      win_cur_len = '0;
    end
    win_centre = win_best_start + ((win_best_len - CntW'(1)) >> 1);
  end

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    settle_cnt_d = settle_cnt_q;
    pt_pass_d    = pt_pass_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    vref_code_d  = vref_code_q;
    pt_en_d      = pt_en_q;
    done_d       = done_q;
    pass_d       = pass_q;
    best_code_d  = best_code_q;
    pass_map_d   = pass_map_q;

    case (state_q)
      StIdle: begin
        if (i_en) begin
          state_d      = StSettle;
          code_d       = MinCode;
          vref_code_d  = MinCode;
          settle_cnt_d = '0;
          pt_pass_d    = 1'b0;
          cur_start_d  = '0;
          cur_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
          pass_d       = 1'b0;
          best_code_d  = DefaultCode;
          pass_map_d   = '0;
        end
      end
      StSettle: begin
        if (settle_cnt_q == SettleLast) begin
          state_d = StRunPt;
          pt_en_d = 1'b1;
        end else begin
          settle_cnt_d = settle_cnt_q + SetW'(1);
        end
      end
      StRunPt: begin
        if (i_pt_done) begin
          pt_pass_d = lane_ok;
          pt_en_d   = 1'b0;
          state_d   = StEval;
        end
      end
      StEval: begin
        cur_start_d  = win_cur_start;
        cur_len_d    = win_cur_len;
        best_start_d = win_best_start;
        best_len_d   = win_best_len;
        if (pt_pass_q) begin
          pass_map_d[code_q] = 1'b1;
        end
        // Terminal check precedes the increment so MAX_CODE = 2^CODE_W-1 never wraps.
        if (code_q == MaxCode) begin
          state_d = StDone;
          done_d  = 1'b1;
          if (win_best_len != '0) begin
            pass_d      = 1'b1;
            best_code_d = win_centre[CODE_W-1:0];
            vref_code_d = win_centre[CODE_W-1:0];
          end else begin
            pass_d      = 1'b0;
            best_code_d = DefaultCode;
            vref_code_d = DefaultCode;
          end
        end else begin
          code_d       = code_inc;
          vref_code_d  = code_inc;
          settle_cnt_d = '0;
          state_d      = StSettle;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (!i_en) begin
      state_d     = StIdle;
      pt_en_d     = 1'b0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      vref_code_d = DefaultCode;
      best_code_d = DefaultCode;
      pass_map_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      code_q       <= MinCode;
      settle_cnt_q <= '0;
      pt_pass_q    <= 1'b0;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      vref_code_q  <= DefaultCode;
      pt_en_q      <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      best_code_q  <= DefaultCode;
      pass_map_q   <= '0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      settle_cnt_q <= settle_cnt_d;
      pt_pass_q    <= pt_pass_d;
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      vref_code_q  <= vref_code_d;
      pt_en_q      <= pt_en_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      best_code_q  <= best_code_d;
      pass_map_q   <= pass_map_d;
    end
  end

  assign o_vref_code = vref_code_q;
  assign o_pt_en     = pt_en_q;
  assign o_done      = done_q;
  assign o_pass      = pass_q;
  assign o_best_code = best_code_q;

`ifdef VREF_SWEEP_BITMAP_EN
  assign o_pass_map = pass_map_q;
`else
  // Without the bitmap output the map register has no reader.
  logic unused_map;
  assign unused_map = ^pass_map_q;
`endif

endmodule
